// File: rtl/serial_sort4_if.sv
// Stream bundle for serial_sort4: value input channel and sorted, index-tagged output channel.
interface serial_sort4_if #(
    parameter int WIDTH = 4,
    parameter int IW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0]    out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/serial_sort4.sv
// Streaming insertion sorter: loads DEPTH values into a sorted slot array, then drains
// them ascending with their arrival index. One slot cell per array position.
module sort4_slot #(
    parameter int WIDTH = 4,
    parameter int IW    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_occ,
    input  logic             i_le_prev,
    input  logic [WIDTH-1:0] i_new_data,
    input  logic [IW-1:0]    i_new_idx,
    input  logic [WIDTH-1:0] i_dn_data,
    input  logic [IW-1:0]    i_dn_idx,
    output logic             o_le,
    output logic [WIDTH-1:0] o_data,
    output logic [IW-1:0]    o_idx
);
    logic [WIDTH-1:0] r_data;
    logic [IW-1:0]    r_idx;

    // Using <= keeps ties stable: the newcomer lands after equal stored values.
    assign o_le   = i_occ && (r_data <= i_new_data);
    assign o_data = r_data;
    assign o_idx  = r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (i_en && !o_le) begin
            if (i_le_prev) begin
                r_data <= i_new_data;
                r_idx  <= i_new_idx;
            end else begin
                r_data <= i_dn_data;
                r_idx  <= i_dn_idx;
            end
        end
    end
endmodule

module serial_sort4 #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    serial_sort4_if.slave  bus,
    output logic           o_busy
);
    typedef enum logic {S_LOAD, S_DRAIN} state_t;

    state_t                       r_state;
    logic [IW:0]                  r_wr_cnt;
    logic [IW-1:0]                r_rd_ptr;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic                         r_busy;

    logic [DEPTH-1:0]             w_le;
    logic [DEPTH-1:0][WIDTH-1:0]  w_data;
    logic [DEPTH-1:0][IW-1:0]     w_idx;
    logic                         w_accept;

    assign w_accept = bus.in_valid && r_in_ready;

    // Slots below the insertion point keep, the insertion slot takes the new value,
    // slots above shift up from their lower neighbour.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic             w_le_prev;
        logic [WIDTH-1:0] w_dn_data;
        logic [IW-1:0]    w_dn_idx;

        if (k == 0) begin : g_bot
            assign w_le_prev = 1'b1;
            assign w_dn_data = '0;
            assign w_dn_idx  = '0;
        end else begin : g_up
            assign w_le_prev = w_le[k-1];
            assign w_dn_data = w_data[k-1];
            assign w_dn_idx  = w_idx[k-1];
        end

        sort4_slot #(.WIDTH(WIDTH), .IW(IW)) u_slot (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_en       (w_accept),
            .i_occ      (r_wr_cnt > (IW+1)'(k)),
            .i_le_prev  (w_le_prev),
            .i_new_data (bus.in_data),
            .i_new_idx  (r_wr_cnt[IW-1:0]),
            .i_dn_data  (w_dn_data),
            .i_dn_idx   (w_dn_idx),
            .o_le       (w_le[k]),
            .o_data     (w_data[k]),
            .o_idx      (w_idx[k])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_LOAD;
            r_wr_cnt    <= '0;
            r_rd_ptr    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                        r_busy   <= 1'b1;
                        if (r_wr_cnt == (IW+1)'(DEPTH-1)) begin
                            r_state     <= S_DRAIN;
                            r_rd_ptr    <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (r_rd_ptr == IW'(DEPTH-1)) begin
                            r_state     <= S_LOAD;
                            r_wr_cnt    <= '0;
                            r_rd_ptr    <= '0;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_valid ? w_data[r_rd_ptr] : '0;
    assign bus.out_idx   = r_out_valid ? w_idx[r_rd_ptr]  : '0;
    assign bus.out_last  = r_out_valid && (r_rd_ptr == IW'(DEPTH-1));
    assign o_busy        = r_busy;
endmodule
